// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for NUM_REQ requesters. The one-hot grant is registered.
// Supports an optional per-requester grant lock (hold) and a downstream stall (en).
module rr_arbiter_n #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INITIAL_PTR = 0,
  parameter bit          HOLD_EN     = 1'b1,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] rq,
  input  logic [NUM_REQ-1:0] hold,
  input  logic               en,
  output logic [NUM_REQ-1:0] gt,
  output logic               gt_valid,
  output logic [IDX_W-1:0]   gt_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] RESET_PTR = IDX_W'(INITIAL_PTR);

  logic [IDX_W-1:0]   ptr;
  logic               lock_c;
  logic               found_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [NUM_REQ-1:0] win_oh_c;
  logic [IDX_W-1:0]   ptr_nxt_c;
  int unsigned        cand_c;

  // The current owner keeps its grant while it still requests and holds.
  always_comb begin
    lock_c = 1'b0;
    if (HOLD_EN) lock_c = |(gt & rq & hold);
  end

  // Wrapping search from ptr; the index wrap is explicit so any NUM_REQ works.
  always_comb begin
    found_c   = 1'b0;
    win_idx_c = '0;
    cand_c    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = int'(ptr) + k;
      if (cand_c >= NUM_REQ) cand_c = cand_c - NUM_REQ;
      if (!found_c && rq[IDX_W'(cand_c)]) begin
        found_c   = 1'b1;
        win_idx_c = IDX_W'(cand_c);
      end
    end
  end

  always_comb begin
    win_oh_c  = '0;
    win_oh_c[win_idx_c] = 1'b1;
    ptr_nxt_c = (win_idx_c == LAST_IDX) ? '0 : IDX_W'(win_idx_c + IDX_W'(1));
  end

  // Arbitration state; en low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gt       <= '0;
      gt_valid <= 1'b0;
      gt_idx   <= '0;
      ptr      <= RESET_PTR;
    end else if (en && !lock_c) begin
      if (found_c) begin
        gt       <= win_oh_c;
        gt_valid <= 1'b1;
        gt_idx   <= win_idx_c;
        ptr      <= ptr_nxt_c;
      end else begin
        gt       <= '0;
        gt_valid <= 1'b0;
        gt_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: default config, no-hold config,
// INITIAL_PTR=2 config and a 3-requester config exercising the non-power-of-2 wrap.
module tb_rr_arbiter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rq, hold;
  logic       en;

  logic [3:0] gt0, gt1, gt2;
  logic       v0, v1, v2, v3;
  logic [1:0] i0, i1, i2, i3;
  logic [2:0] gt3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_n #(.NUM_REQ(4), .INITIAL_PTR(0), .HOLD_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .rq(rq), .hold(hold), .en(en),
    .gt(gt0), .gt_valid(v0), .gt_idx(i0));

  rr_arbiter_n #(.NUM_REQ(4), .INITIAL_PTR(0), .HOLD_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .rq(rq), .hold(hold), .en(en),
    .gt(gt1), .gt_valid(v1), .gt_idx(i1));

  rr_arbiter_n #(.NUM_REQ(4), .INITIAL_PTR(2), .HOLD_EN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .rq(rq), .hold(hold), .en(en),
    .gt(gt2), .gt_valid(v2), .gt_idx(i2));

  rr_arbiter_n #(.NUM_REQ(3), .INITIAL_PTR(0), .HOLD_EN(1'b0)) dut3 (
    .clk(clk), .reset(reset), .rq(rq[2:0]), .hold(hold[2:0]), .en(en),
    .gt(gt3), .gt_valid(v3), .gt_idx(i3));

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [3:0] g, input int unsigned idx);
    chk({tag, " gt"}, gt0, g);
    chk({tag, " idx"}, i0, idx);
    chk({tag, " valid"}, v0, (g != 4'b0000) ? 1 : 0);
  endtask

  int unsigned e0 [5] = '{1, 2, 4, 8, 1};
  int unsigned e2 [5] = '{4, 8, 1, 2, 4};
  int unsigned e3 [5] = '{1, 2, 4, 1, 2};
  int unsigned eh [4] = '{2, 4, 8, 1};

  initial begin
    reset = 1'b0; rq = 4'b1111; hold = 4'b0000; en = 1'b1;
    #1;
    // Reset held low with everyone requesting.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk0("reset d0", 4'b0000, 0);
      chk("reset d2 gt", gt2, 0);
      chk("reset d3 valid", v3, 0);
    end
    reset = 1'b1;

    // Full rotation, one step per cycle.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rot d0 gt", gt0, e0[c]);
      chk("rot d0 idx", i0, (c == 4) ? 0 : c);
      chk("rot d2 gt", gt2, e2[c]);
      chk("rot d3 gt", gt3, e3[c]);
    end

    // Lock requester 0 for 3 more cycles; the no-hold instance keeps rotating.
    hold = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk0("lock d0", 4'b0001, 0);
      chk("nolock d1 gt", gt1, eh[c]);
    end
    hold = 4'b0000;
    tick();
    chk0("unlock d0", 4'b0010, 1);
    chk("nolock d1 gt", gt1, eh[3]);

    // Hold on a non-granted requester is ignored.
    hold = 4'b0001;
    tick();
    chk0("stray hold d0", 4'b0100, 2);
    hold = 4'b0000;
    tick(); chk0("rot2 d0", 4'b1000, 3);
    tick(); chk0("rot2 d0", 4'b0001, 0);
    tick(); chk0("rot2 d0", 4'b0010, 1);

    // Stall: inputs change but nothing moves.
    en = 1'b0; rq = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk0("stall d0", 4'b0010, 1);
    end
    en = 1'b1; rq = 4'b1111;
    tick();
    chk0("unstall d0", 4'b0100, 2);

    // Single requester keeps winning, then another takes over, then idle.
    rq = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk0("single d0", 4'b0100, 2);
    end
    rq = 4'b0001;
    tick(); chk0("switch d0", 4'b0001, 0);
    rq = 4'b0000;
    tick(); chk0("idle d0", 4'b0000, 0);
    chk("idle d1 valid", v1, 0);

    // Dropping the request removes the grant even while hold is set.
    rq = 4'b1111;
    tick(); chk0("resume d0", 4'b0010, 1);
    rq = 4'b1101; hold = 4'b0010;
    tick(); chk0("drop d0", 4'b0100, 2);

    // Asynchronous reset mid-hold; arbitration restarts from INITIAL_PTR.
    rq = 4'b1111; hold = 4'b0100;
    tick(); chk0("prelock d0", 4'b0100, 2);
    reset = 1'b0;
    #2;
    chk0("async rst d0", 4'b0000, 0);
    chk("async rst d2 gt", gt2, 0);
    reset = 1'b1;
    tick();
    chk0("post rst d0", 4'b0001, 0);
    chk("post rst d2 gt", gt2, 4'b0100);
    chk("post rst d2 idx", i2, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
